// File: rtl/computation_pkg.sv
// rtl/computation_pkg.sv - shared op codes, shift codes, status indices and FSM states
package computation_pkg;

  // ALU operation codes; the low two bits match the previous stage
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_MVN = 3'b011;
  localparam logic [2:0] OP_ORR = 3'b100;
  localparam logic [2:0] OP_EOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  // Shift codes applied to operand B
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  // Bit positions inside the {N,Z,V} status register
  localparam int ST_N = 2;
  localparam int ST_Z = 1;
  localparam int ST_V = 0;

  // Control FSM states
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_RUN  = 2'd1,
    S_MUL_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/computation_unit_if.sv
// rtl/computation_unit_if.sv - request/result bus between controller and computation unit
interface computation_unit_if #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 5
) ();
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic [1:0]       shift_op;
  logic [SHW-1:0]   shift_amt;
  logic             asel;
  logic             bsel;
  logic             loadc;
  logic             loads;
  logic [WIDTH-1:0] datapath_in;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [2:0]       status;
  logic             out_valid;
  logic             illegal_op;
  logic             busy;

  // Controller side: issues requests, observes results
  modport master (
    output in_valid, alu_op, shift_op, shift_amt, asel, bsel, loadc, loads,
           datapath_in, A, B,
    input  in_ready, C, status, out_valid, illegal_op, busy
  );

  // Computation unit side
  modport slave (
    input  in_valid, alu_op, shift_op, shift_amt, asel, bsel, loadc, loads,
           datapath_in, A, B,
    output in_ready, C, status, out_valid, illegal_op, busy
  );

endinterface

// File: rtl/computation_shifter.sv
// rtl/computation_shifter.sv - combinational barrel shifter for operand B
module computation_shifter
  import computation_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       op,
  input  logic [SHW-1:0]   amt,
  output logic [WIDTH-1:0] dout
);

  // Select the shift kind; amount 0 falls out as a pass-through in every mode
  always_comb begin
    dout = din;
    case (op)
      SH_LSL:  dout = din << amt;
      SH_LSR:  dout = din >> amt;
      SH_ASR:  dout = $signed(din) >>> amt;
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/computation_unit.sv
// rtl/computation_unit.sv - shift/ALU stage with handshake and optional iterative multiply (COMPUTATION_UNIT_MUL_EN)
module computation_unit
  import computation_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IMM_W = 5
) (
  input logic               clk,
  input logic               rst_n,
  computation_unit_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE      = 1;
  // Low IMM_W bits set; wraps correctly to all-ones when IMM_W == WIDTH
  localparam logic [WIDTH-1:0] IMM_MASK = (ONE << IMM_W) - ONE;

  state_t           state;
  logic [WIDTH-1:0] c_q;
  logic [2:0]       status_q;
  logic             out_valid_q;
  logic             illegal_q;

  logic [WIDTH-1:0] b_shifted;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] res;
  logic             ovf;
  logic [2:0]       flags;
  logic             accept;

`ifdef COMPUTATION_UNIT_MUL_EN
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   count;
  logic             cap_loadc;
  logic             cap_loads;
  logic             busy_q;
`endif

  computation_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .din  (bus.B),
    .op   (bus.shift_op),
    .amt  (bus.shift_amt),
    .dout (b_shifted)
  );

  assign accept = bus.in_valid && (state == S_IDLE);
  assign ain    = bus.asel ? bus.A : '0;
  assign bin    = bus.bsel ? (bus.datapath_in & IMM_MASK) : b_shifted;

  // Single-cycle ALU result and signed-overflow detection
  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (bus.alu_op)
      OP_ADD: begin
        res = ain + bin;
        ovf = (ain[WIDTH-1] == bin[WIDTH-1]) && (res[WIDTH-1] != ain[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        res = ain - bin;
        ovf = (ain[WIDTH-1] != bin[WIDTH-1]) && (res[WIDTH-1] != ain[WIDTH-1]);
      end
      OP_AND:  res = ain & bin;
      OP_MVN:  res = ~bin;
      OP_ORR:  res = ain | bin;
      OP_EOR:  res = ain ^ bin;
      default: res = '0;
    endcase
  end

  // Pack N/Z/V for the single-cycle path
  always_comb begin
    flags       = 3'b000;
    flags[ST_N] = res[WIDTH-1];
    flags[ST_Z] = (res == '0);
    flags[ST_V] = ovf;
  end

  // Control FSM with registered result, status and pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      c_q         <= '0;
      status_q    <= 3'b000;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef COMPUTATION_UNIT_MUL_EN
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      count       <= '0;
      cap_loadc   <= 1'b0;
      cap_loads   <= 1'b0;
      busy_q      <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (bus.alu_op == OP_MUL) begin
`ifdef COMPUTATION_UNIT_MUL_EN
              mcand     <= ain;
              mplier    <= bin;
              acc       <= '0;
              count     <= '0;
              cap_loadc <= bus.loadc;
              cap_loads <= bus.loads;
              busy_q    <= 1'b1;
              state     <= S_MUL_RUN;
`else
              // No multiplier built: flag it and leave C/status untouched
              illegal_q   <= 1'b1;
              out_valid_q <= 1'b1;
`endif
            end else begin
              if (bus.loadc && (bus.alu_op != OP_CMP)) c_q <= res;
              if (bus.loads) status_q <= flags;
              out_valid_q <= 1'b1;
            end
          end
        end
`ifdef COMPUTATION_UNIT_MUL_EN
        S_MUL_RUN: begin
          // One multiplier bit per cycle, LSB first; multiplicand walks left
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == SHW'(WIDTH - 1)) state <= S_MUL_DONE;
        end
        S_MUL_DONE: begin
          if (cap_loadc) c_q <= acc;
          if (cap_loads) status_q <= {acc[WIDTH-1], (acc == '0), 1'b0};
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state       <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == S_IDLE);
  assign bus.C          = c_q;
  assign bus.status     = status_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.illegal_op = illegal_q;
`ifdef COMPUTATION_UNIT_MUL_EN
  assign bus.busy       = busy_q;
`else
  assign bus.busy       = 1'b0;
`endif

endmodule

// File: doc/computation_unit.md
Name: computation_unit

Overview:
Parametrised successor to the datapath computation stage: operand select, variable-amount barrel shift, 8-op ALU, registered result C and N/Z/V status.
- Adds a valid/ready handshake and an iterative multi-cycle multiply.
- Sits between the register file (A, B) and the writeback mux (C), driven by the controller FSM.

Parameters:
WIDTH, 16, datapath width (>=4).
IMM_W, 5, immediate field width taken from datapath_in when bsel=1, zero-extended (IMM_W<=WIDTH).
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request present
in_ready  out  1  unit can accept; high exactly when FSM is IDLE
alu_op  in  3  operation code
shift_op  in  2  00 none, 01 LSL, 10 LSR, 11 ASR
shift_amt  in  SHW  shift distance 0..WIDTH-1
asel  in  1  1: Ain=A; 0: Ain=0
bsel  in  1  1: Bin=zero-extended datapath_in[IMM_W-1:0]; 0: Bin=shifted B
loadc  in  1  commit result to C
loads  in  1  commit flags to status
datapath_in  in  WIDTH  immediate source
A, B  in  WIDTH  operands
C  out  WIDTH  result register
status  out  3  {N,Z,V} register
out_valid  out  1  one-cycle pulse on commit
illegal_op  out  1  one-cycle pulse, unsupported op
busy  out  1  multiply in progress

Behaviour:
- Reset: async on rst_n low. C=0, status=3'b000, out_valid=0, illegal_op=0, busy=0, FSM=IDLE. Reset mid-multiply aborts it silently, with no out_valid.
- Handshake: accept when in_valid && in_ready at a rising edge. All inputs are sampled only at accept and ignored otherwise.
- Op codes (low 2 bits compatible with the previous stage):
  - 000 ADD
  - 001 SUB (Ain-Bin)
  - 010 AND
  - 011 MVN (~Bin)
  - 100 ORR
  - 101 EOR
  - 110 MUL (low WIDTH bits of Ain*Bin)
  - 111 CMP (Ain-Bin, flags only)
- Shift: applied to B before the bsel mux. Amount 0 passes B unchanged. LSL/LSR zero-fill. ASR replicates B[WIDTH-1].
- Flags:
  - N=res[WIDTH-1]; Z=(res==0).
  - V for ADD: operand signs equal and result sign differs. V for SUB/CMP: operand signs differ and result sign differs from Ain. V=0 for all other ops.
  - Arithmetic is modulo 2^WIDTH.
- Non-MUL ops, single cycle: at the accept edge, C<=res if loadc, and status<=flags if loads. out_valid is high during the following cycle. Back-to-back accepts give throughput 1/cycle.
- CMP: never writes C regardless of loadc. Writes status if loads. Pulses out_valid.
- FSM: IDLE, MUL_RUN, MUL_DONE.
  - IDLE, accepting MUL: capture Ain, Bin, loadc, loads; clear accumulator; count=0; go MUL_RUN; busy=1.
  - MUL_RUN: shift-add one multiplier bit per cycle. After WIDTH iterations go MUL_DONE.
  - MUL_DONE: commit C/status per the captured loadc/loads, pulse out_valid, go IDLE.
  - in_ready is low in MUL_RUN and MUL_DONE. A pending in_valid is held off, not dropped.
  - MUL latency: out_valid WIDTH+2 cycles after the accept edge.
- Simultaneous events: out_valid of op k and acceptance of op k+1 may share a cycle. Flags always reflect the most recent committing op.

Optional Feature:
COMPUTATION_UNIT_MUL_EN
- Defined: MUL behaves as above; illegal_op never asserts.
- Undefined: MUL_RUN/MUL_DONE and the multiplier are not built; busy ties to 0. An accepted MUL leaves C and status unchanged, pulses illegal_op and out_valid the next cycle, and costs one cycle.

Decomposition:
- Package computation_pkg:
  - ALU op localparams (OP_ADD..OP_CMP)
  - shift codes (SH_NONE, SH_LSL, SH_LSR, SH_ASR)
  - status bit indices (ST_N=2, ST_Z=1, ST_V=0)
  - FSM state encodings
- Sub-module computation_shifter: combinational barrel shifter, parametrised on WIDTH.
- Multiplier datapath and FSM stay inline.

Test Plan (WIDTH=16, IMM_W=5):
- ADD overflow: asel=1, A=0x7FFF, B=0x0001, shift none, loadc=loads=1 -> C=0x8000, status N=1 Z=0 V=1, out_valid high 1 cycle after accept.
- ASR: asel=0, B=0x8010, shift_op=11, amt=4, ADD -> C=0xF801, N=1, V=0.
- Immediate SUB: bsel=1, datapath_in=0xFFF3, A=0x0005 -> Bin=0x0013, C=0xFFF2, N=1 Z=0 V=0.
- MUL with macro: A=0x0123, B=0x0010 -> C=0x1230 at WIDTH+2 cycles. in_ready low meanwhile; a queued ADD is accepted only after in_ready returns high. Without macro: illegal_op pulse, C/status unchanged.
- CMP equal: A=B=0x00AA, loadc=1, loads=1 -> C unchanged, status Z=1 N=0 V=0.
- Reset mid-MUL: rst_n low 5 cycles after MUL accept -> C=0, status=0, busy=0, in_ready=1 after release, no out_valid.
